// File: rtl/pos_decoder_stream.sv
// Position-decode stream reducer: ORs one-hot decodes of each frame's beats and
// reports mask, saturating beat count and a duplicate flag once per frame.
module pos_decoder_stream #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [2:0]       in_pos,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_mask,
    output logic [CNT_W-1:0] out_count,
    output logic             out_dup,
    input  logic             out_ready
);

    // state | meaning
    // ACCUM | collecting beats of a frame (possibly none yet)
    // HOLD  | frame result presented, waiting for out_ready
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       acc_mask_q, acc_mask_d;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;
    logic             acc_dup_q, acc_dup_d;
    logic [7:0]       out_mask_q, out_mask_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_dup_q, out_dup_d;

    logic             accept;
    logic [7:0]       dec;
    logic [7:0]       sum_mask;
    logic [CNT_W-1:0] sum_count;
    logic             sum_dup;

    always_comb begin
        state_d     = state_q;
        acc_mask_d  = acc_mask_q;
        acc_count_d = acc_count_q;
        acc_dup_d   = acc_dup_q;
        out_mask_d  = out_mask_q;
        out_count_d = out_count_q;
        out_dup_d   = out_dup_q;

        in_ready  = (state_q == ACCUM) || out_ready;
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready;

        dec       = 8'd1 << in_pos;
        sum_mask  = acc_mask_q | dec;
        sum_count = (acc_count_q == CNT_MAX) ? acc_count_q : acc_count_q + CNT_ONE;
        sum_dup   = acc_dup_q || ((acc_mask_q & dec) != 8'd0);

        // The accumulator is always empty while in HOLD, so a beat accepted on
        // the output handshake naturally starts a fresh frame.
        if (accept) begin
            if (in_last) begin
                out_mask_d  = sum_mask;
                out_count_d = sum_count;
                out_dup_d   = sum_dup;
                acc_mask_d  = 8'd0;
                acc_count_d = '0;
                acc_dup_d   = 1'b0;
                state_d     = HOLD;
            end else begin
                acc_mask_d  = sum_mask;
                acc_count_d = sum_count;
                acc_dup_d   = sum_dup;
                state_d     = ACCUM;
            end
        end else if ((state_q == HOLD) && out_ready) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_mask_q  <= 8'd0;
            acc_count_q <= '0;
            acc_dup_q   <= 1'b0;
            out_mask_q  <= 8'd0;
            out_count_q <= '0;
            out_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_mask_q  <= acc_mask_d;
            acc_count_q <= acc_count_d;
            acc_dup_q   <= acc_dup_d;
            out_mask_q  <= out_mask_d;
            out_count_q <= out_count_d;
            out_dup_q   <= out_dup_d;
        end
    end

    assign out_mask  = out_mask_q;
    assign out_count = out_count_q;
    assign out_dup   = out_dup_q;

endmodule

// File: tb/tb_pos_decoder_stream.sv
// Bench for pos_decoder_stream: vector table, hand-written corner sequences and
// randomized stalls scored against a frame-level reference model.
module tb_pos_decoder_stream;

    localparam int CNT_W = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [2:0]       in_pos;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_mask;
    logic [CNT_W-1:0] out_count;
    logic             out_dup;
    logic             out_ready;

    pos_decoder_stream #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pos    (in_pos),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_dup   (out_dup),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] posv;   // beat i position in nibble i
        logic [7:0]  mask;
        int          count;
        logic        dup;
    } vec_t;

    typedef struct {
        logic [7:0] mask;
        int         count;
        logic       dup;
    } res_t;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] m, input int c, input logic d);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_mask"}, 32'(out_mask), 32'(m));
        chk({name, "_count"}, 32'(out_count), 32'(c));
        chk({name, "_dup"}, 32'(out_dup), 32'(d));
    endtask

    task automatic step(input logic v, input logic [2:0] p, input logic l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_pos    = p;
        in_last   = l;
        out_ready = r;
    endtask

    function automatic res_t model(input int f[$]);
        res_t r;
        bit   seen [8];
        r.mask  = 8'd0;
        r.dup   = 1'b0;
        r.count = (f.size() > CNT_SAT) ? CNT_SAT : f.size();
        foreach (seen[i]) seen[i] = 1'b0;
        foreach (f[i]) begin
            if (seen[f[i]]) r.dup = 1'b1;
            seen[f[i]] = 1'b1;
            r.mask[f[i]] = 1'b1;
        end
        return r;
    endfunction

    vec_t vecs [6];
    int   frame [$];
    res_t expq [$];
    res_t r;
    int   sent, delivered;
    logic exp_ready;

    initial begin
        vecs[0] = '{3, 32'h730,      8'h89, 3, 1'b0};
        vecs[1] = '{3, 32'h522,      8'h24, 3, 1'b1};
        vecs[2] = '{1, 32'h4,        8'h10, 1, 1'b0};
        vecs[3] = '{8, 32'h76543210, 8'hff, 8, 1'b0};
        vecs[4] = '{2, 32'h77,       8'h80, 2, 1'b1};
        vecs[5] = '{4, 32'h1616,     8'h42, 4, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_pos = 3'd0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mask", 32'(out_mask), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_dup", 32'(out_dup), 32'd0);

        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].n; i++)
                step(1, vecs[k].posv[i*4 +: 3], i == vecs[k].n - 1, 1);
            step(0, 0, 0, 1);
            #1;
            chk_out($sformatf("vec%0d", k), vecs[k].mask, vecs[k].count, vecs[k].dup);
        end
        step(0, 0, 0, 1);
        #1;
        chk("vec_release", 32'(out_valid), 32'd0);

        // Output stalled in HOLD, then handshake together with a single-beat frame
        step(1, 1, 0, 0);
        step(1, 2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 5, 0, 0);
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk_out("stall_hold", 8'h06, 2, 1'b0);
        end
        step(1, 6, 1, 1);
        step(0, 0, 0, 0);
        #1;
        chk_out("hold_reload", 8'h40, 1, 1'b0);

        // Handshake together with a non-last beat starts the next frame
        step(1, 3, 0, 1);
        #1;
        chk_out("hs_nonlast_prev", 8'h40, 1, 1'b0);
        step(1, 3, 1, 1);
        step(0, 0, 0, 1);
        #1;
        chk_out("hs_nonlast_new", 8'h08, 2, 1'b1);
        step(0, 0, 0, 1);
        #1;
        chk("hs_release", 32'(out_valid), 32'd0);

        // Count saturation
        for (int i = 0; i < 20; i++) step(1, 1, i == 19, 1);
        step(0, 0, 0, 1);
        #1;
        chk_out("saturate", 8'h02, CNT_SAT, 1'b1);

        // Reset mid-frame, with a competing last beat on the reset cycle
        step(1, 4, 0, 1);
        step(1, 5, 0, 1);
        step(1, 2, 1, 1);
        reset = 1'b1;
        step(0, 0, 0, 1);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_mask", 32'(out_mask), 32'd0);
        step(1, 0, 1, 1);
        step(0, 0, 0, 1);
        #1;
        chk_out("after_rst", 8'h01, 1, 1'b0);

        // Reset while a result is pending
        step(0, 0, 0, 0);
        step(1, 7, 1, 0);
        step(0, 0, 0, 0);
        #1;
        chk_out("pre_hold_rst", 8'h80, 1, 1'b0);
        reset = 1'b1;
        step(0, 0, 0, 1);
        reset = 1'b0;
        #1;
        chk("hold_rst_valid", 32'(out_valid), 32'd0);
        chk("hold_rst_mask", 32'(out_mask), 32'd0);

        // Random frames with stalls on both sides
        sent = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc < 3950) begin
                in_valid  = ($urandom_range(9) < 7);
                in_pos    = 3'($urandom_range(7));
                in_last   = ($urandom_range(5) == 0);
                out_ready = ($urandom_range(9) < 6);
            end else begin
                in_valid  = 1'b0;
                in_pos    = 3'($urandom_range(7));
                in_last   = 1'($urandom_range(1));
                out_ready = 1'b1;
            end
            #1;
            exp_ready = (expq.size() == 0) || out_ready;
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
            chk("rnd_out_valid", 32'(out_valid), 32'(expq.size() != 0));
            if (expq.size() != 0 && out_ready) begin
                r = expq.pop_front();
                chk("rnd_mask", 32'(out_mask), 32'(r.mask));
                chk("rnd_count", 32'(out_count), 32'(r.count));
                chk("rnd_dup", 32'(out_dup), 32'(r.dup));
                delivered++;
            end
            if (in_valid && exp_ready) begin
                frame.push_back(int'(in_pos));
                if (in_last) begin
                    expq.push_back(model(frame));
                    frame.delete();
                    sent++;
                end
            end
        end
        chk("rnd_delivered", 32'(delivered), 32'(sent));
        chk("rnd_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
